tof_multichannel: RTL and testbench

- Parametrised multi-channel successor to the single-echo time-of-flight ranger.
- One shared transmit trigger starts a measurement frame. NUM_CH echo receivers are timed against one shared counter.
- A blanking window masks transmit ringing. Each channel captures its first valid echo edge.
- Ranges are computed by a multiply-shift instead of a divide. Results stream out one channel per beat over a valid/ready handshake to the beamforming/display logic.

---
 rtl/tof_multichannel.sv | 166 ++++++++++++++++
 tb/tb_tof_multichannel.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tof_multichannel.sv
// Multi-channel time-of-flight ranger.
// One trigger opens a frame. Each channel latches the counter value at its
// first echo rise after the blanking window. Ranges are then streamed out one
// channel per beat over a valid/ready handshake.
module tof_multichannel #(
    parameter int NUM_CH          = 4,
    parameter int CNT_W           = 20,
    parameter int RANGE_W         = 16,
    parameter int MAX_TIME_WINDOW = 500000,
    parameter int BLANK_CYCLES    = 2000,   // must be >= 1
    parameter int SCALE_MULT      = 11509,
    parameter int SCALE_SHIFT     = 26,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               trigger_in,
    input  logic [NUM_CH-1:0]  echo_in,
    output logic               busy_out,
    output logic               res_valid_out,
    input  logic               res_ready_in,
    output logic [CH_W-1:0]    res_ch_out,
    output logic [RANGE_W-1:0] res_range_out,
    output logic               res_hit_out,
    output logic               res_last_out,
    output logic               frame_done_out
);

    localparam int               PROD_W     = CNT_W + 32;
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_TIME_WINDOW - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_LISTEN, S_REPORT} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_CH-1:0]   echo_prev;
    logic [NUM_CH-1:0]   hit;
    logic [NUM_CH-1:0]   rise_new;
    logic [CNT_W-1:0]    cap [NUM_CH];

    logic                cnt_clr, cnt_inc, cap_en, load_en, frame_end;
    logic [CH_W-1:0]     load_ch;
    logic [RANGE_W-1:0]  load_range;

    // Time-to-range conversion: multiply-shift, clamped to the output width.
    function automatic logic [RANGE_W-1:0] scale_sat(input logic [CNT_W-1:0] t);
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] q;
        prod = PROD_W'(t) * PROD_W'(SCALE_MULT);
        q    = prod >> SCALE_SHIFT;
        if (|(q >> RANGE_W))
            return '1;
        return q[RANGE_W-1:0];
    endfunction

    // First rise on a channel that has not hit yet this frame.
    assign rise_new   = echo_in & ~echo_prev & ~hit;
    assign load_range = hit[load_ch] ? scale_sat(cap[load_ch]) : '0;
    assign busy_out   = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cap_en    = 1'b0;
        load_en   = 1'b0;
        load_ch   = '0;
        frame_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger_in) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_BLANK;
                end
            end
            S_BLANK: begin
                cnt_inc = 1'b1;
                if (cnt >= BLANK_LAST) state_nxt = S_LISTEN;
            end
            S_LISTEN: begin
                cnt_inc = 1'b1;
                cap_en  = 1'b1;
                // A rise on the final cycle is captured before leaving.
                if (((hit | rise_new) == '1) || (cnt == CNT_LAST))
                    state_nxt = S_REPORT;
            end
            S_REPORT: begin
                if (!res_valid_out) begin
                    load_en = 1'b1;
                    load_ch = '0;
                end else if (res_ready_in) begin
                    if (res_last_out) begin
                        frame_end = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        load_en = 1'b1;
                        load_ch = res_ch_out + CH_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame time counter and echo history.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt       <= '0;
            echo_prev <= '0;
        end else begin
            echo_prev <= echo_in;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CNT_W'(1);
        end
    end

    // Per-channel first-echo capture.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit <= '0;
            for (int c = 0; c < NUM_CH; c++) cap[c] <= '0;
        end else begin
            if (cnt_clr)     hit <= '0;
            else if (cap_en) hit <= hit | rise_new;
            for (int c = 0; c < NUM_CH; c++)
                if (cap_en && rise_new[c]) cap[c] <= cnt;
        end
    end

    // Result output register and handshake.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            res_valid_out  <= 1'b0;
            res_ch_out     <= '0;
            res_range_out  <= '0;
            res_hit_out    <= 1'b0;
            res_last_out   <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= frame_end;
            if (load_en) begin
                res_valid_out <= 1'b1;
                res_ch_out    <= load_ch;
                res_range_out <= load_range;
                res_hit_out   <= hit[load_ch];
                res_last_out  <= (load_ch == LAST_CH);
            end else if (frame_end) begin
                res_valid_out <= 1'b0;
                res_ch_out    <= '0;
                res_range_out <= '0;
                res_hit_out   <= 1'b0;
                res_last_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tof_multichannel.sv
// Bench for tof_multichannel: random and directed echo frames against a
// frame-level reference model of first-echo capture and range reporting.
module tb_tof_multichannel;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 20;
    localparam int RW     = 11;
    localparam int MAXW   = 4000;
    localparam int BLANK  = 300;
    localparam int SMUL   = 11509;
    localparam int SSH    = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trig;
    logic [NUM_CH-1:0] echo;
    logic              ready;
    logic              busy, res_valid, res_hit, res_last, frame_done;
    logic [1:0]        res_ch;
    logic [RW-1:0]     res_range;

    int n_chk = 0;
    int n_err = 0;
    int ps [NUM_CH][2];
    int pe [NUM_CH][2];

    tof_multichannel #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RANGE_W(RW), .MAX_TIME_WINDOW(MAXW),
        .BLANK_CYCLES(BLANK), .SCALE_MULT(SMUL), .SCALE_SHIFT(SSH)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .trigger_in(trig), .echo_in(echo),
        .busy_out(busy), .res_valid_out(res_valid), .res_ready_in(ready),
        .res_ch_out(res_ch), .res_range_out(res_range), .res_hit_out(res_hit),
        .res_last_out(res_last), .frame_done_out(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_pulses();
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 2; i++) begin
                ps[c][i] = 0;
                pe[c][i] = 0;
            end
    endtask

    function automatic bit lvl(int c, int k);
        return (k >= ps[c][0] && k < pe[c][0]) || (k >= ps[c][1] && k < pe[c][1]);
    endfunction

    function automatic int exp_range(int t);
        longint p;
        p = (longint'(t) * SMUL) >> SSH;
        if (p > (1 << RW) - 1) return (1 << RW) - 1;
        return int'(p);
    endfunction

    // Random echo pattern for one channel, in counter units.
    task automatic rand_pulses(input int c);
        int m, s;
        m = int'($urandom % 6);
        case (m)
            1: begin s = 10 + int'($urandom % (BLANK - 40)); ps[c][0] = s; pe[c][0] = s + 5 + int'($urandom % 10); end
            2: begin
                ps[c][0] = BLANK - 10; pe[c][0] = BLANK + 30;
                s = BLANK + 60 + int'($urandom % 1000); ps[c][1] = s; pe[c][1] = s + 4;
            end
            3: begin s = BLANK + int'($urandom % (MAXW - BLANK)); ps[c][0] = s; pe[c][0] = s + 1 + int'($urandom % 20); end
            4: begin s = MAXW - 2 + int'($urandom % 3); ps[c][0] = s; pe[c][0] = s + 3; end
            5: begin
                ps[c][0] = 50; pe[c][0] = 60;
                s = BLANK + int'($urandom % 2500); ps[c][1] = s; pe[c][1] = s + 2;
            end
            default: ;
        endcase
    endtask

    task automatic run_frame(input bit bp);
        int  fr [NUM_CH];
        int  e, k, gv, b, cyc, hold;
        bit  allhit, rdy, sv;
        logic [1:0]    sch;
        logic [RW-1:0] srg;
        // reference: first rise inside the listen window, frame end time
        allhit = 1'b1;
        e = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            fr[c] = -1;
            for (int t = BLANK; t < MAXW; t++)
                if (lvl(c, t) && !lvl(c, t - 1)) begin fr[c] = t; break; end
            if (fr[c] < 0) allhit = 1'b0;
            else if (fr[c] > e) e = fr[c];
        end
        if (!allhit) e = MAXW - 1;

        echo = '0; trig = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        chk("busy_rise", busy, 1);

        gv = -1;
        for (k = 0; k <= MAXW + 8; k++) begin
            for (int c = 0; c < NUM_CH; c++) echo[c] = lvl(c, k);
            @(posedge clk); #1;
            if (res_valid) begin gv = k; break; end
        end
        chk("valid_latency", gv, e + 1);
        if (gv < 0) return;

        b = 0; hold = 0;
        for (cyc = 0; cyc < 200 && b < NUM_CH; cyc++) begin
            rdy = ($urandom % 4) != 0;
            if (bp && res_valid && res_ch == 2'd1 && hold < 10) begin rdy = 1'b0; hold++; end
            ready = rdy;
            trig  = (rdy && res_valid && res_last) ? 1'b0 : 1'($urandom % 2);
            echo  = NUM_CH'($urandom);
            sv = res_valid; sch = res_ch; srg = res_range;
            chk("busy_report", busy, 1);
            if (res_valid && rdy) begin
                chk("beat_ch", res_ch, b);
                chk("beat_hit", res_hit, (fr[b] >= 0 && fr[b] <= e) ? 1 : 0);
                chk("beat_range", res_range, (fr[b] >= 0 && fr[b] <= e) ? exp_range(fr[b]) : 0);
                chk("beat_last", res_last, (b == NUM_CH - 1) ? 1 : 0);
                b++;
            end
            @(posedge clk); #1;
            if (sv && !rdy) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_ch", res_ch, sch);
                chk("hold_range", res_range, srg);
            end
        end
        trig = 1'b0; ready = 1'b0; echo = '0;
        chk("beat_count", b, NUM_CH);
        chk("frame_done_pulse", frame_done, 1);
        chk("valid_drop", res_valid, 0);
        chk("busy_idle", busy, 0);
        @(posedge clk); #1;
        chk("frame_done_once", frame_done, 0);
        chk("trig_not_queued", busy, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_ch"}, res_ch, 0);
        chk({tag, "_range"}, res_range, 0);
        chk({tag, "_hit"}, res_hit, 0);
        chk({tag, "_last"}, res_last, 0);
        chk({tag, "_done"}, frame_done, 0);
    endtask

    initial begin
        rst_n = 1'b0; trig = 1'b0; echo = '0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        #3 rst_n = 1'b1;

        // single hit on ch1, timeout
        clear_pulses(); ps[1][0] = 1000; pe[1][0] = 1010;
        run_frame(1'b0);
        // blanked rise then late rise (saturating range)
        clear_pulses(); ps[0][0] = 100; pe[0][0] = 120; ps[0][1] = 3000; pe[0][1] = 3005;
        run_frame(1'b0);
        // all channels in the same cycle: early completion
        clear_pulses();
        for (int c = 0; c < NUM_CH; c++) begin ps[c][0] = 1500; pe[c][0] = 1520; end
        run_frame(1'b0);
        // timeout boundary, late rise, echo already high at listen start
        clear_pulses();
        ps[2][0] = MAXW - 1; pe[2][0] = MAXW + 2;
        ps[0][0] = MAXW;     pe[0][0] = MAXW + 2;
        ps[1][0] = BLANK - 5; pe[1][0] = BLANK + 40;
        ps[3][0] = BLANK;    pe[3][0] = BLANK + 1;
        run_frame(1'b0);
        // backpressure on ch1
        clear_pulses();
        for (int c = 0; c < NUM_CH; c++) begin ps[c][0] = 600 + 37 * c; pe[c][0] = 610 + 37 * c; end
        run_frame(1'b1);

        // reset in the middle of listening
        clear_pulses(); ps[0][0] = BLANK + 10; pe[0][0] = BLANK + 20;
        @(posedge clk); #1;
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        for (int k = 0; k < BLANK + 50; k++) begin
            for (int c = 0; c < NUM_CH; c++) echo[c] = lvl(c, k);
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        echo = '0;
        #20 rst_n = 1'b1;
        clear_pulses(); ps[3][0] = 800; pe[3][0] = 805;
        run_frame(1'b0);

        for (int f = 0; f < 10; f++) begin
            clear_pulses();
            for (int c = 0; c < NUM_CH; c++) rand_pulses(c);
            run_frame(1'($urandom % 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
